// File: rtl/csa_accum_ctrl.sv
// Accumulation controller for an external carry-save compressor tree.
// Operands are batched into slots; one COMPRESS cycle folds them into acc_s/acc_c.
module csa_accum_ctrl #(
  parameter int NUM_ELEMENTS = 9,
  parameter int BIT_LEN      = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [BIT_LEN-1:0] in_data_i,
  input  logic               in_last_i,
  output logic [BIT_LEN-1:0] tree_terms_o [NUM_ELEMENTS],
  input  logic [BIT_LEN-1:0] tree_s_i,
  input  logic [BIT_LEN-1:0] tree_c_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [BIT_LEN-1:0] out_sum_o,
  output logic [15:0]        out_count_o
);

  localparam int NSLOT = NUM_ELEMENTS - 2;
  localparam int SW    = (NSLOT > 1) ? $clog2(NSLOT + 1) : 1;

  typedef enum logic [1:0] {S_FILL, S_COMPRESS, S_FINAL, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [BIT_LEN-1:0] acc_s_q, acc_s_d;
  logic [BIT_LEN-1:0] acc_c_q, acc_c_d;
  logic [BIT_LEN-1:0] slots_q [NSLOT];
  logic [BIT_LEN-1:0] slots_d [NSLOT];
  logic [SW-1:0]      slot_cnt_q, slot_cnt_d;
  logic               last_q, last_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [BIT_LEN-1:0] out_sum_q, out_sum_d;

  logic accept, out_hs, slot_full;

  assign accept    = in_valid_i & in_ready_o;
  assign out_hs    = out_valid_o & out_ready_i;
  assign slot_full = (slot_cnt_q == SW'(NSLOT - 1));

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_FILL;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FILL:     if (accept && (slot_full || in_last_i)) state_d = S_COMPRESS;
      S_COMPRESS: state_d = last_q ? S_FINAL : S_FILL;
      S_FINAL:    state_d = S_DONE;
      S_DONE:     if (out_hs) state_d = S_FILL;
      default:    state_d = S_FILL;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready_o  = (state_q == S_FILL);
    out_valid_o = (state_q == S_DONE);
  end

  // Datapath next-state
  always_comb begin
    acc_s_d    = acc_s_q;
    acc_c_d    = acc_c_q;
    slots_d    = slots_q;
    slot_cnt_d = slot_cnt_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    out_sum_d  = out_sum_q;
    case (state_q)
      S_FILL: if (accept) begin
        for (int i = 0; i < NSLOT; i++)
          if (slot_cnt_q == SW'(i)) slots_d[i] = in_data_i;
        slot_cnt_d = slot_cnt_q + SW'(1);
        cnt_d      = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        last_d     = last_q | in_last_i;
      end
      S_COMPRESS: begin
        // Clearing slots keeps a short final pass from re-adding stale operands.
        acc_s_d    = tree_s_i;
        acc_c_d    = tree_c_i;
        for (int i = 0; i < NSLOT; i++) slots_d[i] = '0;
        slot_cnt_d = '0;
      end
      S_FINAL: out_sum_d = acc_s_q + acc_c_q;
      S_DONE: if (out_hs) begin
        acc_s_d = '0;
        acc_c_d = '0;
        last_d  = 1'b0;
        cnt_d   = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_s_q    <= '0;
      acc_c_q    <= '0;
      for (int i = 0; i < NSLOT; i++) slots_q[i] <= '0;
      slot_cnt_q <= '0;
      last_q     <= 1'b0;
      cnt_q      <= '0;
      out_sum_q  <= '0;
    end else begin
      acc_s_q    <= acc_s_d;
      acc_c_q    <= acc_c_d;
      slots_q    <= slots_d;
      slot_cnt_q <= slot_cnt_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      out_sum_q  <= out_sum_d;
    end
  end

  always_comb begin
    tree_terms_o[0] = acc_s_q;
    tree_terms_o[1] = acc_c_q;
    for (int i = 0; i < NSLOT; i++) tree_terms_o[i+2] = slots_q[i];
  end

  assign out_sum_o   = out_sum_q;
  assign out_count_o = cnt_q;

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Directed bench for csa_accum_ctrl with a behavioural compressor tree model.
module tb_csa_accum_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        in_last = 1'b0;
  logic [15:0] terms [9];
  logic [15:0] tree_s, tree_c;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_sum;
  logic [15:0] out_count;

  int tests = 0;
  int fails = 0;
  int stall_cnt = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  csa_accum_ctrl #(.NUM_ELEMENTS(9), .BIT_LEN(16)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_data_i(in_data), .in_last_i(in_last), .tree_terms_o(terms),
    .tree_s_i(tree_s), .tree_c_i(tree_c), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .out_sum_o(out_sum), .out_count_o(out_count)
  );

  // Tree model: splits the true sum into a nonzero carry part and the remainder.
  always_comb begin
    logic [15:0] total;
    total = '0;
    for (int i = 0; i < 9; i++) total = total + terms[i];
    tree_c = {terms[2][14:0], 1'b0} & terms[3];
    tree_s = total - tree_c;
  end

  always @(negedge clk) if (mon_en && !in_ready && !out_valid) stall_cnt++;

  task automatic send(input logic [15:0] d, input logic l);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL send_timeout: in_ready stuck at %0b, required 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_out();
    int n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    tests++;
    if (out_valid !== 1'b1) begin
      fails++; $display("FAIL out_timeout: out_valid=%0b, required 1", out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready: got %0b want 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
    tests++; if (out_sum !== 16'h0) begin fails++; $display("FAIL rst_out_sum: got %h want 0000", out_sum); end
    tests++; if (out_count !== 16'h0) begin fails++; $display("FAIL rst_out_count: got %0d want 0", out_count); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [15:0] ops [9];
    for (int i = 0; i < 9; i++) ops[i] = 16'((1 << (i + 1)) - 1);
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) send(ops[i], 1'b0);
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL b2b_stall: in_ready=%0b want 0", in_ready); end
    @(posedge clk); #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_resume: in_ready=%0b want 1", in_ready); end
    send(ops[7], 1'b0);
    send(ops[8], 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    wait_out();
    tests++; if (out_sum !== 16'h03F5) begin fails++; $display("FAIL b2b_sum: got %h want 03f5", out_sum); end
    tests++; if (out_count !== 16'd9) begin fails++; $display("FAIL b2b_count: got %0d want 9", out_count); end
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_release: out_valid=%0b want 0", out_valid); end
  endtask

  task automatic test_single();
    logic [2:0] vseq;
    send(16'h1234, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    // Cycles t+1, t+2, t+3 after the accepting edge
    vseq[0] = out_valid; @(posedge clk); #1;
    vseq[1] = out_valid; @(posedge clk); #1;
    vseq[2] = out_valid;
    tests++; if (vseq !== 3'b100) begin fails++; $display("FAIL single_latency: out_valid seq %b want 100", vseq); end
    tests++; if (out_sum !== 16'h1234) begin fails++; $display("FAIL single_sum: got %h want 1234", out_sum); end
    tests++; if (out_count !== 16'd1) begin fails++; $display("FAIL single_count: got %0d want 1", out_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    send(16'hFFFF, 1'b0);
    send(16'h0002, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    wait_out();
    tests++; if (out_sum !== 16'h0001) begin fails++; $display("FAIL wrap_sum: got %h want 0001", out_sum); end
    tests++; if (out_count !== 16'd2) begin fails++; $display("FAIL wrap_count: got %0d want 2", out_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int bad = 0;
    out_ready = 1'b0;
    send(16'h0010, 1'b0);
    send(16'h0020, 1'b1);
    in_valid = 1'b1; in_data = 16'h0099; in_last = 1'b1;
    wait_out();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || out_sum !== 16'h0030 || in_ready !== 1'b0 || out_count !== 16'd2) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL bp_hold: %0d bad cycles, want 0 (sum=%h)", bad, out_sum); end
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL bp_release: out_valid=%0b in_ready=%0b want 0/1", out_valid, in_ready);
    end
    send(16'h0007, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    wait_out();
    tests++; if (out_sum !== 16'h0007 || out_count !== 16'd1) begin
      fails++; $display("FAIL bp_fresh: sum=%h count=%0d want 0007/1", out_sum, out_count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) send(16'h0100 + 16'(i), 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests++; if (terms[2] !== 16'h0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL mid_rst_state: slot0=%h in_ready=%0b out_valid=%0b want 0000/1/0", terms[2], in_ready, out_valid);
    end
    send(16'h0005, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    wait_out();
    tests++; if (out_sum !== 16'h0005 || out_count !== 16'd1) begin
      fails++; $display("FAIL mid_rst_result: sum=%h count=%0d want 0005/1", out_sum, out_count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_multi_pass();
    stall_cnt = 0;
    mon_en = 1'b1;
    for (int i = 0; i < 14; i++) send(16'h0001, (i == 13));
    in_valid = 1'b0; in_last = 1'b0;
    wait_out();
    mon_en = 1'b0;
    // Two COMPRESS stalls plus the FINAL cycle
    tests++; if (stall_cnt != 3) begin fails++; $display("FAIL multi_stalls: got %0d want 3", stall_cnt); end
    tests++; if (out_sum !== 16'h000E || out_count !== 16'd14) begin
      fails++; $display("FAIL multi_result: sum=%h count=%0d want 000e/14", out_sum, out_count);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_single();
    test_wrap();
    test_backpressure();
    test_reset_mid();
    test_multi_pass();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
